// File: rtl/dmem_write_buffer.sv
// Posted write buffer between dcache and data_memory: queues write-back blocks,
// drains them in the background and forwards read hits from the queue.
module dmem_write_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic                     up_read,
    input  logic                     up_write,
    input  logic [ADDR_W-1:0]        up_address,
    input  logic [DATA_W-1:0]        up_writedata,
    output logic [DATA_W-1:0]        up_readdata,
    output logic                     up_busywait,
    output logic                     dm_read,
    output logic                     dm_write,
    output logic [ADDR_W-1:0]        dm_address,
    output logic [DATA_W-1:0]        dm_writedata,
    input  logic [DATA_W-1:0]        dm_readdata,
    input  logic                     dm_busywait,
    output logic [$clog2(DEPTH):0]   buf_count,
    output logic [1:0]               fsm_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_READ  = 2'd2
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr_mem [DEPTH];
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_W-1:0]    count;
    logic                up_ack;
    logic                gap;

    logic                push;
    logic                pop;
    logic                rd_req;
    logic                hit;
    logic [DATA_W-1:0]   hit_data;
    logic [PTR_W-1:0]    idx;
    logic                hit_done;
    logic                miss_pending;
    logic                read_done;

    // Upstream handshake: a request is held until up_ack pulses for one cycle;
    // busywait stalls the cache for every cycle of a held request except that one.
    assign up_busywait  = (up_read | up_write) & ~up_ack;

    assign push         = up_write & ~up_ack & (count < CNT_W'(DEPTH));
    assign pop          = (state == S_DRAIN) & ~dm_busywait;
    assign read_done    = (state == S_READ) & ~dm_busywait;
    assign rd_req       = up_read & ~up_write & ~up_ack;
    assign hit_done     = rd_req & hit & (state != S_READ);
    assign miss_pending = rd_req & ~hit;

    assign buf_count    = count;
    assign fsm_state    = state;

    // Scan oldest to newest so the last match (closest to tail) wins; the head
    // entry leaving on this edge is excluded from forwarding.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && !(pop && (i == 0)) &&
                (addr_mem[idx] == up_address)) begin
                hit      = 1'b1;
                hit_data = data_mem[idx];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[tail] <= up_address;
            data_mem[tail] <= up_writedata;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state        <= S_IDLE;
            up_ack       <= 1'b0;
            gap          <= 1'b0;
            up_readdata  <= '0;
            dm_read      <= 1'b0;
            dm_write     <= 1'b0;
            dm_address   <= '0;
            dm_writedata <= '0;
        end else begin
            up_ack <= push | hit_done | read_done;
            gap    <= 1'b0;
            if (hit_done) begin
                up_readdata <= hit_data;
            end
            case (state)
                S_IDLE: begin
                    // A waiting read miss beats a pending drain, but only here.
                    if (miss_pending) begin
                        state      <= S_READ;
                        dm_read    <= 1'b1;
                        dm_address <= up_address;
                    end else if ((count != '0) && !gap) begin
                        state        <= S_DRAIN;
                        dm_write     <= 1'b1;
                        dm_address   <= addr_mem[head];
                        dm_writedata <= data_mem[head];
                    end
                end
                S_DRAIN: begin
                    if (!dm_busywait) begin
                        state    <= S_IDLE;
                        dm_write <= 1'b0;
                        gap      <= 1'b1;
                    end
                end
                S_READ: begin
                    if (!dm_busywait) begin
                        state       <= S_IDLE;
                        dm_read     <= 1'b0;
                        up_readdata <= dm_readdata;
                        gap         <= 1'b1;
                    end
                end
                default: begin
                    state    <= S_IDLE;
                    dm_read  <= 1'b0;
                    dm_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Directed bench for dmem_write_buffer: drivers push expectations into queues,
// negedge monitors pop and compare on upstream read acks and memory writes.
`timescale 1ns/1ps
module tb_dmem_write_buffer;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              up_read = 1'b0;
    logic              up_write = 1'b0;
    logic [ADDR_W-1:0] up_address = '0;
    logic [DATA_W-1:0] up_writedata = '0;
    logic [DATA_W-1:0] up_readdata;
    logic              up_busywait;
    logic              dm_read;
    logic              dm_write;
    logic [ADDR_W-1:0] dm_address;
    logic [DATA_W-1:0] dm_writedata;
    logic [DATA_W-1:0] dm_readdata;
    logic              dm_busywait;
    logic [2:0]        buf_count;
    logic [1:0]        fsm_state;

    dmem_write_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RESET(RESET),
        .up_read(up_read), .up_write(up_write), .up_address(up_address),
        .up_writedata(up_writedata), .up_readdata(up_readdata), .up_busywait(up_busywait),
        .dm_read(dm_read), .dm_write(dm_write), .dm_address(dm_address),
        .dm_writedata(dm_writedata), .dm_readdata(dm_readdata), .dm_busywait(dm_busywait),
        .buf_count(buf_count), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset / memory model ----------------
    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] mem [64];
    logic [63:0]       mem_valid = '0;
    logic              hold_busy = 1'b0;
    int                lat_cnt = 0;
    int                cyc = 0;

    // Unwritten locations return 0xA50000_<addr>.
    function automatic logic [DATA_W-1:0] mem_rd(input logic [ADDR_W-1:0] a);
        return mem_valid[a] ? mem[a] : (32'hA500_0000 | {26'd0, a});
    endfunction

    assign dm_busywait = hold_busy | ((dm_read | dm_write) & (lat_cnt < 2));
    assign dm_readdata = mem_rd(dm_address);

    always @(posedge CLK) begin
        cyc     <= cyc + 1;
        lat_cnt <= (dm_read | dm_write) ? lat_cnt + 1 : 0;
        if (RESET && dm_write && !dm_busywait) begin
            mem[dm_address]       <= dm_writedata;
            mem_valid[dm_address] <= 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [ADDR_W+DATA_W-1:0] exp_wr_q[$];
    logic [DATA_W-1:0]        exp_rd_q[$];
    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    int rd_cnt = 0;
    int wr_cyc_cnt = 0;
    int rd_rise_cyc = -100;
    int wr_done_cyc = 0;
    logic prev_rd = 1'b0;

    always @(negedge CLK) begin
        if (dm_read) rd_cnt++;
        if (dm_write) wr_cyc_cnt++;
        if (dm_read && !prev_rd) rd_rise_cyc = cyc;
        prev_rd = dm_read;
        if (dm_read && dm_write) check("dm_strobe_overlap", 1, 0);
        if (dm_write && !dm_busywait) begin
            wr_done_cyc = cyc;
            if (exp_wr_q.size() == 0) check("dm_write_unexpected", {26'd0, dm_address, dm_writedata}, 0);
            else check("dm_write_block", {26'd0, dm_address, dm_writedata}, {26'd0, exp_wr_q.pop_front()});
        end
        if (up_read && !up_busywait) begin
            if (exp_rd_q.size() == 0) check("rd_unexpected", {32'd0, up_readdata}, 0);
            else check("rd_data", {32'd0, up_readdata}, {32'd0, exp_rd_q.pop_front()});
        end
    end

    // ---------------- drivers ----------------
    task automatic align();
        @(posedge CLK);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the request is dropped.
    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                            input bit expect_drain, output int stall);
        up_write = 1'b1;
        up_address = a;
        up_writedata = d;
        if (expect_drain) exp_wr_q.push_back({a, d});
        stall = 0;
        @(negedge CLK);
        while (up_busywait && stall < 300) begin
            stall++;
            @(negedge CLK);
        end
        if (up_busywait) check("write_ack_timeout", 1, 0);
        @(posedge CLK);
        #1;
        up_write = 1'b0;
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, output int stall);
        up_read = 1'b1;
        up_address = a;
        exp_rd_q.push_back(d);
        stall = 0;
        @(negedge CLK);
        while (up_busywait && stall < 300) begin
            stall++;
            @(negedge CLK);
        end
        if (up_busywait) check("read_ack_timeout", 1, 0);
        @(posedge CLK);
        #1;
        up_read = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        @(negedge CLK);
        while (!(buf_count == 0 && fsm_state == 2'd0 && !dm_write) && k < 500) begin
            k++;
            @(negedge CLK);
        end
        if (k >= 500) check("drain_timeout", 1, 0);
        align();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int st;
        int w0;
        int r0;
        #1 RESET = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;
        @(negedge CLK);
        check("reset_buf_count", buf_count, 0);
        check("reset_dm_read", dm_read, 0);
        check("reset_dm_write", dm_write, 0);
        check("reset_dm_address", dm_address, 0);
        check("reset_fsm_state", fsm_state, 0);
        check("reset_busywait", up_busywait, 0);
        align();

        // single write, then drain
        do_write(6'h05, 32'hDEAD_BEEF, 1, st);
        check("wr_stall_cycles", st, 1);
        check("wr_buf_count", buf_count, 1);
        wait_idle();
        check("mem_05", mem_rd(6'h05), 32'hDEAD_BEEF);

        // fill to DEPTH with drain blocked, fifth write stalls until a pop
        hold_busy = 1'b1;
        for (int i = 1; i <= 4; i++) do_write(6'(i), 32'h1000_0000 + i, 1, st);
        check("full_buf_count", buf_count, 4);
        fork
            do_write(6'h05, 32'h1000_0005, 1, st);
            begin
                repeat (4) @(negedge CLK);
                check("full_write_stalled", up_busywait, 1);
                check("full_count_held", buf_count, 4);
                align();
                hold_busy = 1'b0;
            end
        join
        wait_idle();

        // duplicate address: forward the newest copy, no memory read
        hold_busy = 1'b1;
        do_write(6'h0A, 32'h1111_1111, 1, st);
        do_write(6'h0A, 32'h2222_2222, 1, st);
        check("dup_buf_count", buf_count, 2);
        r0 = rd_cnt;
        do_read(6'h0A, 32'h2222_2222, st);
        check("hit_stall_cycles", st, 1);
        check("hit_no_dm_read", rd_cnt - r0, 0);
        hold_busy = 1'b0;
        wait_idle();

        // read miss waits behind an in-flight drain plus the gap cycle
        hold_busy = 1'b1;
        do_write(6'h01, 32'h0000_0101, 1, st);
        check("drain_in_flight", dm_write, 1);
        fork
            do_read(6'h20, 32'hA500_0020, st);
            begin
                repeat (3) @(negedge CLK);
                align();
                hold_busy = 1'b0;
            end
        join
        check("miss_after_gap", rd_rise_cyc - wr_done_cyc, 2);
        wait_idle();
        check("mem_01", mem_rd(6'h01), 32'h0000_0101);

        // reset mid-drain discards three queued blocks
        hold_busy = 1'b1;
        do_write(6'h11, 32'hBAD0_0011, 0, st);
        do_write(6'h12, 32'hBAD0_0012, 0, st);
        do_write(6'h13, 32'hBAD0_0013, 0, st);
        check("pre_reset_count", buf_count, 3);
        @(negedge CLK);
        #1 RESET = 1'b0;
        #1;
        check("rst_dm_write", dm_write, 0);
        check("rst_dm_address", dm_address, 0);
        check("rst_dm_writedata", dm_writedata, 0);
        check("rst_buf_count", buf_count, 0);
        w0 = wr_cyc_cnt;
        hold_busy = 1'b0;
        #1 RESET = 1'b1;
        repeat (20) @(negedge CLK);
        check("no_write_after_reset", wr_cyc_cnt - w0, 0);
        check("post_reset_mem_11", mem_rd(6'h11), 32'hA500_0011);
        align();

        // move pointers to 3, then push and pop on the same edge across the wrap
        do_write(6'h30, 32'h3000_0030, 1, st);
        do_write(6'h31, 32'h3000_0031, 1, st);
        do_write(6'h32, 32'h3000_0032, 1, st);
        wait_idle();
        hold_busy = 1'b1;
        do_write(6'h3A, 32'hAAAA_0001, 1, st);
        do_write(6'h3B, 32'hBBBB_0002, 1, st);
        check("wrap_count_before", buf_count, 2);
        hold_busy = 1'b0;
        do_write(6'h3C, 32'hCCCC_0003, 1, st);
        check("push_pop_count", buf_count, 2);
        do_read(6'h3B, 32'hBBBB_0002, st);
        check("wrap_hit_stall", st, 1);
        wait_idle();
        check("mem_3c", mem_rd(6'h3C), 32'hCCCC_0003);

        check("exp_wr_q_empty", exp_wr_q.size(), 0);
        check("exp_rd_q_empty", exp_rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_write_buffer.md
# dmem_write_buffer

Posted write buffer between `dcache` and `data_memory`. It absorbs dcache write-back blocks (32-bit block, 6-bit block address), so the cache does not stall for the full memory write time. Buffered blocks drain to `data_memory` in the background. Read misses are served from the buffer when they hit a queued block; otherwise they go to memory after any in-flight drain completes. Upstream ports mirror the `data_memory` port, and downstream ports drive `data_memory` unchanged.

## Interface
- `DEPTH`, 4, number of entries (power of 2, ≥2)
- `ADDR_W`, 6, block address width
- `DATA_W`, 32, block data width
- `CLK` in 1: system clock, rising edge
- `RESET` in 1: asynchronous, active-low reset
- `up_read` in 1: dcache read request, held until acknowledged
- `up_write` in 1: dcache write request, held until acknowledged
- `up_address` in ADDR_W: request block address
- `up_writedata` in DATA_W: write block
- `up_readdata` out DATA_W: read block; valid while `up_ack`=1 after a read
- `up_busywait` out 1: stall to dcache
- `dm_read` out 1: read strobe to data_memory
- `dm_write` out 1: write strobe to data_memory
- `dm_address` out ADDR_W: block address to data_memory
- `dm_writedata` out DATA_W: write block to data_memory
- `dm_readdata` in DATA_W: block returned by data_memory
- `dm_busywait` in 1: data_memory stall
- `buf_count` out $clog2(DEPTH)+1: current occupancy

## Operation
- **Storage:** circular FIFO of {address, data}, with head/tail pointers that wrap modulo DEPTH, plus a count.
- **Upstream handshake:**
  - `up_busywait = (up_read | up_write) & ~up_ack`, combinational.
  - `up_ack` is an internal register, pulsed high for exactly one cycle after a request completes.
  - No request is accepted while `up_ack`=1.
- **Write:**
  - Accepted at the first rising edge where `up_write`=1, `up_ack`=0 and count<DEPTH: the entry is appended at tail and `up_ack` is set.
  - When full, the write waits with `up_busywait` high.
  - No coalescing: a duplicate address appends a new entry.
- **Read hit:**
  - A hit is any valid entry whose address equals `up_address`.
  - Data comes from the newest matching entry (closest to tail).
  - It completes at the first edge with `up_ack`=0: `up_readdata` is registered and `up_ack` is set.
- **Read miss:** waits until the drain FSM is IDLE, then the FSM enters READ.
- **Drain FSM:**
  - IDLE:
    - Read miss pending → READ.
    - Otherwise, count>0 and no gap flag set → DRAIN.
  - DRAIN:
    - `dm_write`=1 with the head entry.
    - At an edge with `dm_busywait`=0, pop the head, set the gap flag, and go to IDLE.
  - READ:
    - `dm_read`=1 with `up_address`.
    - At an edge with `dm_busywait`=0, capture `dm_readdata` into `up_readdata`, set `up_ack`, set the gap flag, and go to IDLE.
  - Gap flag: forces `dm_read`=`dm_write`=0 for at least one cycle between memory transactions. It clears after one cycle.
  - Read misses have priority over drain only at IDLE; an in-flight drain always completes first.
- **Simultaneous enqueue and pop at the same edge:** count unchanged, and both pointers advance.
- **Forwarding during pop:** an entry popped at edge N is not a hit candidate for a read accepted at edge N.
- **Reset (asserted, any time):**
  - All pointers and the count are cleared, the FSM goes to IDLE, and `up_ack` and the gap flag are cleared.
  - `dm_read`, `dm_write`, `dm_address`, `dm_writedata` and `up_readdata` go to 0.
  - Buffered data is discarded, including reset mid-DRAIN or mid-READ.

## Timing
- `dm_*` outputs are registered from FSM state; `up_busywait` is combinational.
- Write with space: request in cycle 0, accepted at edge 1, `up_busywait` low in cycle 1. Total stall is 1 cycle.
- Read hit: same timing as a write; `up_readdata` is valid in cycle 1.
- Read miss, FSM IDLE:
  - READ is entered at edge 1, and `dm_read` goes high in cycle 1.
  - Completion comes at the first edge with `dm_busywait`=0; `up_ack` is high in the following cycle.
- Drain can start in the cycle after an enqueue, provided no read miss is pending.
- `buf_count` updates at the same edge as the push or pop.

## Test plan
- Reset, then write addr 0x05 data 0xDEADBEEF: busywait for 1 cycle, `buf_count`=1; after drain, memory[0x05]=0xDEADBEEF and `buf_count`=0.
- Four writes (0x01..0x04) while `dm_busywait` is held high: `buf_count`=4; a fifth write stalls until the first pop, then is accepted; drain order is 0x01,0x02,0x03,0x04,0x05.
- Writes 0x0A=0x11111111 then 0x0A=0x22222222 with drain blocked, then a read of 0x0A: `up_readdata`=0x22222222 after 1 stall cycle, with `dm_read` never asserted.
- Read miss of 0x20 while the 0x01 drain is in flight: `dm_read` rises only after the `dm_write` completion plus a 1-cycle gap, and returns memory[0x20].
- Pulse `RESET` low mid-DRAIN with 3 entries: outputs go to 0 immediately, `buf_count`=0, and no further `dm_write` occurs.
- Write and pop on the same edge with `buf_count`=2: `buf_count` remains 2, and pointers wrap correctly past DEPTH-1.
